// File: rtl/jk_flip_flop.sv
// jk_flip_flop: bank of WIDTH independent edge-triggered JK flip-flops.
// Shares one rising-edge clock and two asynchronous active-low controls.
// Clear forces Q to zero and beats Preset. Preset forces Q to all ones.
// Q_prim is always the bitwise complement of Q.

module jk_flip_flop #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             Preset,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_prim
);

    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONE  = {WIDTH{1'b1}};

    // Stored flip-flop state.
    logic [WIDTH-1:0] q_r;

    // Next state from the JK rule, evaluated per bit.
    logic [WIDTH-1:0] q_next_s;

    // Q as seen at the outputs, including any live async override.
    logic [WIDTH-1:0] q_out_s;

    // Per-bit JK rule: 00 hold, 01 reset, 10 set, 11 toggle.
    always_comb begin
        q_next_s = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            case ({J[i], K[i]})
                2'b00:   q_next_s[i] = q_r[i];
                2'b01:   q_next_s[i] = 1'b0;
                2'b10:   q_next_s[i] = 1'b1;
                2'b11:   q_next_s[i] = ~q_r[i];
                default: q_next_s[i] = q_r[i];
            endcase
        end
    end

    // State register.
    // Async Clear has priority over async Preset.
    // Clock edges are ignored while either control is low.
    always_ff @(posedge CLK or negedge Clear or negedge Preset) begin
        if (!Clear) begin
            q_r <= ALL_ZERO;
        end else if (!Preset) begin
            q_r <= ALL_ONE;
        end else begin
            q_r <= q_next_s;
        end
    end

    // Output view follows the async control levels directly.
    // Releasing Clear while Preset is still low has no edge to trigger
    // the register. This override therefore shows the preset value
    // immediately. In every other state it simply passes q_r through.
    always_comb begin
        q_out_s = q_r;
        if (!Clear) begin
            q_out_s = ALL_ZERO;
        end else if (!Preset) begin
            q_out_s = ALL_ONE;
        end else begin
            q_out_s = q_r;
        end
    end

    assign Q      = q_out_s;
    assign Q_prim = ~q_out_s;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Self-checking bench for jk_flip_flop (WIDTH=4).
// Directed sequence first, then randomized J/K with async pulses.
// All results are compared against a behavioural model.

module tb_jk_flip_flop;

    localparam int W = 4;

    logic         clk_s;
    logic         clear_s;
    logic         preset_s;
    logic [W-1:0] j_s;
    logic [W-1:0] k_s;
    logic [W-1:0] q_s;
    logic [W-1:0] q_prim_s;

    int n_checks;
    int n_errors;

    // Behavioural model of the expected stored value.
    logic [W-1:0] q_m;

    jk_flip_flop #(.WIDTH(W)) dut (
        .CLK    (clk_s),
        .Clear  (clear_s),
        .Preset (preset_s),
        .J      (j_s),
        .K      (k_s),
        .Q      (q_s),
        .Q_prim (q_prim_s)
    );

    // Clock with 10 ns period; rising edges at 5, 15, 25, ...
    initial begin
        clk_s = 1'b0;
        forever #5 clk_s = ~clk_s;
    end

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Check both outputs against the model value.
    task automatic check_q(input string tag, input logic [W-1:0] exp);
        check_val({tag, "_q"}, q_s, exp);
        check_val({tag, "_qp"}, q_prim_s, ~exp);
    endtask

    // Characteristic equation of a JK flip-flop:
    // q+ = J & ~q | ~K & q, applied to all bits at once.
    function automatic logic [W-1:0] jk_model(input logic [W-1:0] q, input logic [W-1:0] j, input logic [W-1:0] k);
        return (j & ~q) | (~k & q);
    endfunction

    initial begin
        logic [2:0] mode;
        n_checks = 0;
        n_errors = 0;

        // t=0: preset asserted, J=1 K=0 on all bits.
        clear_s  = 1'b1;
        j_s      = 4'hF;
        k_s      = 4'h0;
        preset_s = 1'b0;
        #1;  check_q("preset_t1", 4'hF);
        #29; check_q("preset_hold_edges", 4'hF);         // t=30

        // t=28 style: Clear low forces 0 immediately.
        #8;  preset_s = 1'b1; clear_s = 1'b0;             // t=38
        #1;  check_q("clear_immediate", 4'h0);            // t=39
        #20; check_q("clear_hold_edges", 4'h0);           // t=59, edges 45/55 ignored

        // Release Clear mid-cycle: no change until the next rising edge.
        #4;  clear_s = 1'b1; j_s = 4'hF; k_s = 4'h0;      // t=63
        #1;  check_q("release_no_change", 4'h0);          // t=64
        #2;  check_q("set_after_edge", 4'hF);             // t=66, edge 65

        // Hold mode.
        #2;  j_s = 4'h0; k_s = 4'h0;                      // t=68
        #22; check_q("hold", 4'hF);                       // t=90, edges 75/85

        // Reset mode.
        #3;  k_s = 4'hF;                                  // t=93
        #3;  check_q("reset_jk", 4'h0);                   // t=96, edge 95

        // Toggle mode.
        #2;  j_s = 4'hF; k_s = 4'hF;                      // t=98
        #8;  check_q("toggle1", 4'hF);                    // t=106
        #10; check_q("toggle2", 4'h0);                    // t=116
        #10; check_q("toggle3", 4'hF);                    // t=126

        // Both controls low: Clear wins. Release Clear first: preset shows.
        #2;  clear_s = 1'b0; preset_s = 1'b0;             // t=128
        #1;  check_q("both_low", 4'h0);                   // t=129
        #4;  clear_s = 1'b1;                              // t=133
        #1;  check_q("preset_only", 4'hF);                // t=134
        #4;  clear_s = 1'b0; preset_s = 1'b1;             // t=138
        #1;  check_q("clear_again", 4'h0);

        // Load 0011, then apply mixed J/K across bits.
        #4;  clear_s = 1'b1; j_s = 4'b0011; k_s = 4'b0000; // t=143
        #3;  check_q("load_0011", 4'b0011);               // t=146
        #2;  j_s = 4'b1010; k_s = 4'b0110;                // t=148
        #8;  check_q("mixed_jk", 4'b1001);                // t=156

        // Randomized phase.
        q_m = 4'b1001;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_s);
            j_s  = W'($urandom);
            k_s  = W'($urandom);
            mode = 3'($urandom_range(0, 7));
            if (mode == 3'd0) begin
                // Short clear pulse between edges.
                #1; clear_s = 1'b0; q_m = 4'h0;
                #1; check_q("rnd_clear", q_m);
                #1; clear_s = 1'b1;
                #1; check_q("rnd_clear_rel", q_m);
            end else if (mode == 3'd1) begin
                // Preset held across the rising edge.
                #1; preset_s = 1'b0; q_m = 4'hF;
                #1; check_q("rnd_preset", q_m);
            end else begin
                // No async activity this cycle.
            end
            @(posedge clk_s);
            if (mode != 3'd1) begin
                q_m = jk_model(q_m, j_s, k_s);
            end else begin
                // Edge ignored while preset is low.
            end
            #1;
            check_q("rnd_edge", q_m);
            if (mode == 3'd1) begin
                preset_s = 1'b1;
            end else begin
                // Preset stays high.
            end
            // J/K changes between edges must not affect Q.
            j_s = W'($urandom);
            k_s = W'($urandom);
            #2;
            check_q("rnd_between", q_m);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/jk_flip_flop.md
Name: jk_flip_flop

Overview:
- Edge-triggered JK flip-flop with asynchronous active-low preset and clear, and complementary outputs.
- Used as a basic storage/toggle element in counters and small sequential circuits.
- Optionally replicated WIDTH times as a bank of independent bit-slices sharing one clock, preset and clear.

Parameters:
- WIDTH, 1, number of independent JK bit-slices. Each bit of J/K/Q/Q_prim is one flip-flop.

Ports:
- CLK  input  1  clock; state updates on the rising edge only.
- Clear  input  1  asynchronous active-low reset; forces Q=0. This is the block reset.
- Preset  input  1  asynchronous active-low set; forces Q=all ones.
- J  input  WIDTH  per-bit J input.
- K  input  WIDTH  per-bit K input.
- Q  output  WIDTH  stored state.
- Q_prim  output  WIDTH  complement of Q.

Interface note: one clock (CLK); reset is asynchronous and active-low (Clear). Preset is likewise asynchronous active-low.

Behaviour:
- Q_prim == ~Q at all times, bitwise, including during reset and preset. There is no state in which Q and Q_prim are equal.
- Asynchronous priority:
  - Clear=0 -> Q=0 immediately, independent of CLK.
  - Preset=0 with Clear=1 -> Q=all ones immediately.
  - Both low -> Clear wins: Q=0, Q_prim=all ones.
- While either async input is low, clock edges are ignored.
- Release of Clear/Preset:
  - No immediate change; Q holds its forced value.
  - The first rising CLK edge with both high applies the JK rule below.
- Synchronous rule, rising CLK edge, Clear=1 and Preset=1, per bit i:
  - J=0,K=0 -> hold.
  - J=0,K=1 -> Q[i]=0.
  - J=1,K=0 -> Q[i]=1.
  - J=1,K=1 -> Q[i]=~Q[i] (toggle).
- Latency: Q reflects the new value after the same rising edge (one edge, no extra pipeline). Q_prim is combinational from Q.
- J/K changes between edges have no effect; no level sensitivity to J/K.
- Power-up before any Clear/Preset: Q is undefined (X in simulation). Benches must apply Clear or Preset first.
- Toggle mode with J=K=1 held: Q alternates every rising edge, i.e. half the CLK frequency.
- No X-pessimism requirements beyond standard RTL. Implementation is a single always block sensitive to posedge CLK, negedge Clear, negedge Preset.

Test Plan:
- Preset=0, Clear=1, J=1, K=0 from t=0 (CLK period 10 ns, rising edges at 5,15,25 ns) -> Q=1, Q_prim=0 from t=0, unchanged across edges 5/15/25.
- At t=28 Preset=1, Clear=0 -> Q=0, Q_prim=1 immediately at 28, not waiting for the edge. Holds through edges 35/45 despite J=1.
- At t=53 Clear=1, J=1, K=0 -> Q still 0 until rising edge at 55, then Q=1, Q_prim=0.
- At t=78 J=0, K=0 -> Q holds 1 across edges 85/95. At t=103 J=0, K=1 -> Q=0 at edge 105.
- At t=128 J=1, K=1 -> Q toggles each rising edge: 1 at 135, 0 at 145, 1 at 155, and so on. Q_prim always its complement.
- Preset=0 and Clear=0 simultaneously, then Clear released first -> Q=0 while both low, then Q=1 once only Preset is low. With WIDTH=4, J=4'b1010, K=4'b0110, Q=4'b0011 -> after one edge Q=4'b1001.
